// File: rtl/ovl_seq_sched_pkg.sv
// Shared types and helpers for the shared cycle-sequence scheduler.
// Optional coverage counters in the top are enabled by OVL_SEQ_SCHED_COVER_EN.
package ovl_seq_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      ABORT = 2'd1,
      FIRE  = 2'd2
   } result_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin search: first set req bit at or after rr_ptr, wrapping.
module ovl_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               vld
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      gnt      = '0;
      idx      = '0;
      vld      = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand     = (int'(rr_ptr) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!vld && req[cand_idx]) begin
            vld           = 1'b1;
            idx           = cand_idx;
            gnt[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ovl_cycle_sequence_scheduler.sv
// One cycle-sequence tracking engine shared round-robin among NUM_REQ channels.
// Define OVL_SEQ_SCHED_COVER_EN to add saturating pass/fire/miss counters.
module ovl_cycle_sequence_scheduler
   import ovl_seq_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_CKS = 3,
   localparam int IDX_W  = clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] ev,
   output logic [NUM_REQ-1:0] gnt,
   output logic               busy,
   output logic               pass,
   output logic               abort,
   output logic               fire,
   output logic [IDX_W-1:0]   result_id,
`ifdef OVL_SEQ_SCHED_COVER_EN
   output logic [15:0]        pass_cnt,
   output logic [15:0]        fire_cnt,
   output logic [15:0]        miss_cnt,
`endif
   output logic               miss
);

   localparam int                STEP_W    = clog2(NUM_CKS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_CKS - 1);

   state_e               state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   gnt_d;
   logic                 busy_d;
   logic                 miss_d;
   logic                 res_vld_d;
   result_e              res_d;
   logic                 pass_d, abort_d, fire_d;
   logic                 ev_own;
   logic                 multi_req;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_vld;

   ovl_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .gnt    (arb_gnt),
      .idx    (arb_idx),
      .vld    (arb_vld)
   );

   assign ev_own    = ev[owner_q];
   assign multi_req = (req & (req - NUM_REQ'(1))) != '0;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt;
      busy_d    = busy;
      miss_d    = 1'b0;
      res_vld_d = 1'b0;
      res_d     = PASS;
      case (state_q)
         IDLE: begin
            miss_d = multi_req;
            if (arb_vld) begin
               state_d = TRACK;
               step_d  = STEP_W'(1);
               owner_d = arb_idx;
               gnt_d   = arb_gnt;
               busy_d  = 1'b1;
            end
         end
         TRACK: begin
            // Still tracking at this edge, so any request here is dropped.
            miss_d = |req;
            if (step_q == LAST_STEP) begin
               res_vld_d = 1'b1;
               res_d     = ev_own ? PASS : FIRE;
            end else if (!ev_own) begin
               res_vld_d = 1'b1;
               res_d     = ABORT;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
            if (res_vld_d) begin
               state_d  = IDLE;
               gnt_d    = '0;
               busy_d   = 1'b0;
               rr_ptr_d = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pass_d  = res_vld_d && (res_d == PASS);
   assign abort_d = res_vld_d && (res_d == ABORT);
   assign fire_d  = res_vld_d && (res_d == FIRE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         pass      <= 1'b0;
         abort     <= 1'b0;
         fire      <= 1'b0;
         miss      <= 1'b0;
         result_id <= '0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         gnt      <= gnt_d;
         busy     <= busy_d;
         pass     <= pass_d;
         abort    <= abort_d;
         fire     <= fire_d;
         miss     <= miss_d;
         if (res_vld_d) result_id <= owner_q;
      end
   end

`ifdef OVL_SEQ_SCHED_COVER_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Counters advance on the same edge that launches their pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pass_cnt <= '0;
         fire_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         if (pass_d) pass_cnt <= sat_inc(pass_cnt);
         if (fire_d) fire_cnt <= sat_inc(fire_cnt);
         if (miss_d) miss_cnt <= sat_inc(miss_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ovl_cycle_sequence_scheduler.sv
// Bench for ovl_cycle_sequence_scheduler: vector table, corner sequences, random vs model.
module tb_ovl_cycle_sequence_scheduler;

   localparam int NUM_REQ = 4;
   localparam int NUM_CKS = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] ev = '0;
   logic [3:0] gnt;
   logic       busy, pass, abort, fire, miss;
   logic [1:0] result_id;
`ifdef OVL_SEQ_SCHED_COVER_EN
   logic [15:0] pass_cnt, fire_cnt, miss_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ovl_cycle_sequence_scheduler #(
      .NUM_REQ (NUM_REQ),
      .NUM_CKS (NUM_CKS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .ev        (ev),
      .gnt       (gnt),
      .busy      (busy),
      .pass      (pass),
      .abort     (abort),
      .fire      (fire),
      .result_id (result_id),
`ifdef OVL_SEQ_SCHED_COVER_EN
      .pass_cnt  (pass_cnt),
      .fire_cnt  (fire_cnt),
      .miss_cnt  (miss_cnt),
`endif
      .miss      (miss)
   );

   // Packed observation: {gnt[3:0], busy, pass, abort, fire, result_id[1:0], miss}
   function automatic logic [10:0] mk(input logic [3:0] g, input logic b, input logic p,
                                      input logic a, input logic f, input logic [1:0] id,
                                      input logic m);
      return {g, b, p, a, f, id, m};
   endfunction

   function automatic logic [10:0] obs();
      return {gnt, busy, pass, abort, fire, result_id, miss};
   endfunction

   task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual gnt=%b busy=%b pass=%b abort=%b fire=%b id=%0d miss=%b required gnt=%b busy=%b pass=%b abort=%b fire=%b id=%0d miss=%b",
                  nm, act[10:7], act[6], act[5], act[4], act[3], act[2:1], act[0],
                  exp[10:7], exp[6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] e);
      req = r;
      ev  = e;
      @(posedge clk);
      #1;
   endtask

   // Reset pulse starting 1 after an edge, released on the following negedge.
   task automatic do_reset();
      reset_n = 1'b0;
      req = '0;
      ev  = '0;
      #4;
      reset_n = 1'b1;
   endtask

   // Sequence-level reference: a grant opens a window of NUM_CKS-1 ev samples
   // from the owner; the first zero before the last sample aborts, the last
   // sample decides pass or fire.
   bit         m_busy;
   logic [1:0] m_owner;
   int         m_ptr;
   logic [1:0] m_rid;
   bit         m_hist[$];

   task automatic model_init();
      m_busy  = 0;
      m_owner = '0;
      m_ptr   = 0;
      m_rid   = '0;
      m_hist.delete();
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [3:0] e, output logic [10:0] exp);
      logic p, a, f, ms;
      logic [1:0] k;
      p = 0; a = 0; f = 0; ms = 0;
      if (m_busy) begin
         ms = (r != 0);
         m_hist.push_back(e[m_owner]);
         if (m_hist.size() == NUM_CKS - 1) begin
            if (e[m_owner]) p = 1; else f = 1;
         end else if (!e[m_owner]) a = 1;
         if (p | a | f) begin
            m_rid  = m_owner;
            m_ptr  = (int'(m_owner) + 1) % NUM_REQ;
            m_busy = 0;
            m_hist.delete();
         end
      end else begin
         ms = ($countones(r) > 1);
         for (int i = 0; i < NUM_REQ; i++) begin
            k = 2'((m_ptr + i) % NUM_REQ);
            if (!m_busy && r[k]) begin
               m_owner = k;
               m_busy  = 1;
            end
         end
      end
      exp = mk(m_busy ? (4'b0001 << m_owner) : 4'b0000, m_busy, p, a, f, m_rid, ms);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  ev;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[15];

   initial begin
      logic [10:0] exp;
      logic [3:0]  r, e;

      tbl[0]  = '{4'b0010, 4'b0000, mk(4'b0010, 1, 0, 0, 0, 2'd0, 0)};
      tbl[1]  = '{4'b0000, 4'b0010, mk(4'b0010, 1, 0, 0, 0, 2'd0, 0)};
      tbl[2]  = '{4'b0000, 4'b0010, mk(4'b0000, 0, 1, 0, 0, 2'd1, 0)};
      tbl[3]  = '{4'b0010, 4'b0000, mk(4'b0010, 1, 0, 0, 0, 2'd1, 0)};
      tbl[4]  = '{4'b0000, 4'b0000, mk(4'b0000, 0, 0, 1, 0, 2'd1, 0)};
      tbl[5]  = '{4'b0010, 4'b0000, mk(4'b0010, 1, 0, 0, 0, 2'd1, 0)};
      tbl[6]  = '{4'b0000, 4'b0010, mk(4'b0010, 1, 0, 0, 0, 2'd1, 0)};
      tbl[7]  = '{4'b0000, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 2'd1, 0)};
      tbl[8]  = '{4'b0001, 4'b0000, mk(4'b0001, 1, 0, 0, 0, 2'd1, 0)};
      tbl[9]  = '{4'b1000, 4'b0001, mk(4'b0001, 1, 0, 0, 0, 2'd1, 1)};
      tbl[10] = '{4'b0000, 4'b0001, mk(4'b0000, 0, 1, 0, 0, 2'd0, 0)};
      tbl[11] = '{4'b1001, 4'b0000, mk(4'b1000, 1, 0, 0, 0, 2'd0, 1)};
      tbl[12] = '{4'b0000, 4'b1000, mk(4'b1000, 1, 0, 0, 0, 2'd0, 0)};
      tbl[13] = '{4'b0100, 4'b0000, mk(4'b0000, 0, 0, 0, 1, 2'd3, 1)};
      tbl[14] = '{4'b0000, 4'b0000, mk(4'b0000, 0, 0, 0, 0, 2'd3, 0)};

      #12;
      check("reset_state", obs(), 11'b0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].req, tbl[i].ev);
         check($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // Fair rotation with all channels requesting, each sampled while idle.
      do_reset();
      drive(4'b1111, 4'b0000);
      check("rr_grant_ch0", obs(), mk(4'b0001, 1, 0, 0, 0, 2'd0, 1));
      drive(4'b0000, 4'b0000);
      check("rr_abort_ch0", obs(), mk(4'b0000, 0, 0, 1, 0, 2'd0, 0));
      drive(4'b1111, 4'b0000);
      check("rr_grant_ch1", obs(), mk(4'b0010, 1, 0, 0, 0, 2'd0, 1));
      drive(4'b0000, 4'b0000);
      check("rr_abort_ch1", obs(), mk(4'b0000, 0, 0, 1, 0, 2'd1, 0));
      drive(4'b1111, 4'b0000);
      check("rr_grant_ch2", obs(), mk(4'b0100, 1, 0, 0, 0, 2'd1, 1));

      // Asynchronous reset in the middle of a sequence.
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_clear", obs(), 11'b0);
      @(posedge clk);
      #1;
      check("reset_no_result", obs(), 11'b0);
      #4;
      reset_n = 1'b1;
      drive(4'b1111, 4'b0000);
      check("post_reset_grant_ch0", obs(), mk(4'b0001, 1, 0, 0, 0, 2'd0, 1));
      drive(4'b0000, 4'b0001);
      drive(4'b0000, 4'b0001);
      check("post_reset_pass", obs(), mk(4'b0000, 0, 1, 0, 0, 2'd0, 0));

      // Random traffic against the sequence-level model.
      do_reset();
      model_init();
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         e = 4'($urandom) | 4'($urandom);
         drive(r, e);
         model_edge(r, e, exp);
         check($sformatf("rand%0d", n), obs(), exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
